// File: rtl/encoder4to2_queued_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | encoder4to2_queued_if                                                |
// | Request/encoded-output bundle for the queued 4-to-2 request encoder. |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
interface encoder4to2_queued_if;
  logic       En;       // capture enable
  logic [3:0] i;        // request strobes
  logic [1:0] o;        // encoded index of presented request
  logic       valid;    // o holds a request
  logic       ready;    // consumer accepts o when valid && ready
  logic       overrun;  // strobe merged into an already-pending line
  logic       busy;     // valid or anything pending

  // Encoder side: takes strobes and ready, produces the encoded stream.
  modport master (
    input  En, i, ready,
    output o, valid, overrun, busy
  );

  // Source/consumer side: the mirror image of the encoder.
  modport slave (
    output En, i, ready,
    input  o, valid, overrun, busy
  );
endinterface
`default_nettype wire

// File: rtl/encoder4to2_queued.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | encoder4to2_queued                                                   |
// | Captures single-cycle strobes on four request lines into a pending   |
// | register and emits them one at a time as 2-bit codes over a          |
// | valid/ready handshake, in fixed priority order.                      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module encoder4to2_queued #(
  parameter bit HIGH_FIRST = 1'b1  // 1: line 3 wins, 0: line 0 wins
) (
  input  logic                   clk,
  input  logic                   rst,
  encoder4to2_queued_if.master   bus
);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] pending_q, pending_d;
  logic [1:0] o_q, o_d;
  logic       overrun_q, overrun_d;

  logic       hit;
  logic [1:0] sel_idx;
  logic       load;
  logic [3:0] take;
  logic [3:0] strobe;

  // Pick the highest-priority line from the registered pending set only.
  always_comb begin
    hit     = |pending_q;
    sel_idx = 2'b00;
    if (HIGH_FIRST) begin
      for (int k = 0; k < 4; k++) begin
        if (pending_q[k]) sel_idx = 2'(k);
      end
    end else begin
      for (int k = 3; k >= 0; k--) begin
        if (pending_q[k]) sel_idx = 2'(k);
      end
    end
  end

  // Next-state: output load/handshake, capture and collision detection.
  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    take    = 4'b0000;
    load    = (state_q == S_EMPTY) || bus.ready;
    if (load) begin
      if (hit) begin
        o_d     = sel_idx;
        take    = 4'b0001 << sel_idx;
        state_d = S_HOLD;
      end else begin
        o_d     = 2'b00;
        state_d = S_EMPTY;
      end
    end
    strobe    = bus.En ? bus.i : 4'b0000;
    // A strobe on a line being taken this edge simply re-queues it.
    pending_d = (pending_q & ~take) | strobe;
    overrun_d = |(strobe & pending_q & ~take);
  end

  // State, output register and overrun pulse; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_EMPTY;
      pending_q <= 4'b0000;
      o_q       <= 2'b00;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      o_q       <= o_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.o       = o_q;
  assign bus.valid   = (state_q == S_HOLD);
  assign bus.overrun = overrun_q;
  assign bus.busy    = (state_q == S_HOLD) | (|pending_q);

endmodule
`default_nettype wire
